// File: rtl/expr_eval_pkg.sv
// Shared opcode definitions and opcode-class helpers for the expression evaluator.
package expr_eval_pkg;

    localparam int OPC_W = 4;

    typedef enum logic [OPC_W-1:0] {
        OP_ADD     = 4'd0,
        OP_SUB     = 4'd1,
        OP_AND     = 4'd2,
        OP_OR      = 4'd3,
        OP_XOR     = 4'd4,
        OP_XNOR    = 4'd5,
        OP_SHL     = 4'd6,
        OP_SHR     = 4'd7,
        OP_ASHR    = 4'd8,
        OP_LT      = 4'd9,
        OP_LE      = 4'd10,
        OP_EQ      = 4'd11,
        OP_RED_AND = 4'd12,
        OP_RED_OR  = 4'd13,
        OP_RED_XOR = 4'd14,
        OP_MUX     = 4'd15
    } opcode_e;

    function automatic logic is_compare(input opcode_e op);
        return (op == OP_LT) || (op == OP_LE) || (op == OP_EQ);
    endfunction

    function automatic logic is_reduce(input opcode_e op);
        return (op == OP_RED_AND) || (op == OP_RED_OR) || (op == OP_RED_XOR);
    endfunction

endpackage

// File: rtl/expr_eval_alu.sv
// Combinational datapath: operand extension to OW bits followed by the opcode mux.
module expr_eval_alu
    import expr_eval_pkg::*;
#(
    parameter int W  = 4,
    parameter int OW = 6
) (
    input  logic [OPC_W-1:0] opcode,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic             a_signed,
    input  logic             b_signed,
    output logic [OW-1:0]    result
);

    logic          sgn;
    logic [OW-1:0] ax;
    logic [OW-1:0] bx;
    logic [OW-1:0] wide;
    logic          flag;
    opcode_e       op;

    // Mixed signedness evaluates as unsigned, so only both-signed sign-extends.
    assign sgn = a_signed && b_signed;
    assign op  = opcode_e'(opcode);

    assign ax[W-1:0] = a;
    assign bx[W-1:0] = b;

    generate
        for (genvar gi = W; gi < OW; gi++) begin : g_ext
            assign ax[gi] = sgn & a[W-1];
            assign bx[gi] = sgn & b[W-1];
        end
    endgenerate

    always_comb begin
        wide = '0;
        flag = 1'b0;
        case (op)
            OP_ADD:  wide = ax + bx;
            OP_SUB:  wide = ax - bx;
            OP_AND:  wide = ax & bx;
            OP_OR:   wide = ax | bx;
            OP_XOR:  wide = ax ^ bx;
            OP_XNOR: wide = ~(ax ^ bx);
            // Shift amounts use the raw W bits of b; oversize amounts shift out fully.
            OP_SHL:  wide = ax << b;
            OP_SHR:  wide = ax >> b;
            OP_ASHR: begin
                if (sgn) begin
                    wide = $signed(ax) >>> b;
                end else begin
                    wide = ax >> b;
                end
            end
            OP_LT:   flag = sgn ? ($signed(ax) <  $signed(bx)) : (ax <  bx);
            OP_LE:   flag = sgn ? ($signed(ax) <= $signed(bx)) : (ax <= bx);
            OP_EQ:   flag = (ax == bx);
            OP_RED_AND: flag = &a;
            OP_RED_OR:  flag = |a;
            OP_RED_XOR: flag = ^a;
            OP_MUX:  wide = (|a) ? bx : ~bx;
            default: wide = '0;
        endcase

        if (is_compare(op) || is_reduce(op)) begin
            result = {{(OW-1){1'b0}}, flag};
        end else begin
            result = wide;
        end
    end

endmodule

// File: rtl/expr_eval_pipe.sv
// Two-stage valid/ready expression evaluator with rolling signature and result counter.
module expr_eval_pipe
    import expr_eval_pkg::*;
#(
    parameter int W     = 4,
    parameter int OW    = 6,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPC_W-1:0] opcode,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic             a_signed,
    input  logic             b_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OW-1:0]    out_data,
    input  logic             sig_clr,
    output logic [OW-1:0]    sig,
    output logic [CNT_W-1:0] res_cnt
);

    logic             s1_valid_reg;
    logic [OPC_W-1:0] s1_op_reg;
    logic [W-1:0]     s1_a_reg;
    logic [W-1:0]     s1_b_reg;
    logic             s1_as_reg;
    logic             s1_bs_reg;

    logic             s2_valid_reg;
    logic [OW-1:0]    s2_data_reg;

    logic [OW-1:0]    sig_reg;
    logic [OW-1:0]    sig_next;
    logic [OW-1:0]    sig_rot;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    logic [OW-1:0]    alu_result;
    logic             s2_free;
    logic             accept;
    logic             out_hs;

    expr_eval_alu #(
        .W  (W),
        .OW (OW)
    ) u_alu (
        .opcode   (s1_op_reg),
        .a        (s1_a_reg),
        .b        (s1_b_reg),
        .a_signed (s1_as_reg),
        .b_signed (s1_bs_reg),
        .result   (alu_result)
    );

    // S2 can take a new result when empty or being drained this cycle; S1
    // then follows the same rule against S2, which gives full rate with no bubbles.
    assign s2_free  = !s2_valid_reg || out_ready;
    assign in_ready = !s1_valid_reg || s2_free;
    assign accept   = in_valid && in_ready;
    assign out_hs   = s2_valid_reg && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_reg <= 1'b0;
            s1_op_reg    <= '0;
            s1_a_reg     <= '0;
            s1_b_reg     <= '0;
            s1_as_reg    <= 1'b0;
            s1_bs_reg    <= 1'b0;
            s2_valid_reg <= 1'b0;
            s2_data_reg  <= '0;
        end else begin
            if (in_ready) begin
                s1_valid_reg <= in_valid;
            end
            if (accept) begin
                s1_op_reg <= opcode;
                s1_a_reg  <= a;
                s1_b_reg  <= b;
                s1_as_reg <= a_signed;
                s1_bs_reg <= b_signed;
            end
            if (s2_free) begin
                s2_valid_reg <= s1_valid_reg;
                if (s1_valid_reg) begin
                    s2_data_reg <= alu_result;
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < OW; gi++) begin : g_rot
            assign sig_rot[gi] = sig_reg[(gi + OW - 1) % OW];
        end
    endgenerate

    // A clear coinciding with a handshake restarts the signature from that result.
    always_comb begin
        sig_next = sig_reg;
        cnt_next = cnt_reg;
        if (sig_clr) begin
            sig_next = out_hs ? s2_data_reg : '0;
            cnt_next = out_hs ? CNT_W'(1) : '0;
        end else if (out_hs) begin
            sig_next = sig_rot ^ s2_data_reg;
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sig_reg <= '0;
            cnt_reg <= '0;
        end else begin
            sig_reg <= sig_next;
            cnt_reg <= cnt_next;
        end
    end

    assign out_valid = s2_valid_reg;
    assign out_data  = s2_data_reg;
    assign sig       = sig_reg;
    assign res_cnt   = cnt_reg;

endmodule

// File: tb/tb_expr_eval_pipe.sv
// Vector table plus scoreboard bench for expr_eval_pipe at W=4, OW=6.
module tb_expr_eval_pipe;
    import expr_eval_pkg::*;

    localparam int W     = 4;
    localparam int OW    = 6;
    localparam int CNT_W = 16;
    localparam int NVEC  = 38;

    typedef struct {
        logic [3:0]    op;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic          as_;
        logic          bs_;
        logic [OW-1:0] exp;
    } vec_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       opcode;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             a_signed;
    logic             b_signed;
    logic             out_valid;
    logic             out_ready;
    logic [OW-1:0]    out_data;
    logic             sig_clr;
    logic [OW-1:0]    sig;
    logic [CNT_W-1:0] res_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [OW-1:0]    q_exp[$];
    int               q_id[$];
    logic [OW-1:0]    cur_exp;
    int               cur_id;
    logic [OW-1:0]    msig;
    logic [CNT_W-1:0] mcnt;

    vec_t vecs[NVEC];
    vec_t bp[4];

    expr_eval_pipe #(
        .W     (W),
        .OW    (OW),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .a         (a),
        .b         (b),
        .a_signed  (a_signed),
        .b_signed  (b_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .sig_clr   (sig_clr),
        .sig       (sig),
        .res_cnt   (res_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input vec_t v, input int id);
        opcode   = v.op;
        a        = v.a;
        b        = v.b;
        a_signed = v.as_;
        b_signed = v.bs_;
        cur_exp  = v.exp;
        cur_id   = id;
    endtask

    task automatic send(input vec_t v, input int id);
        bit done = 0;
        set_vec(v, id);
        in_valid = 1'b1;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clk);
            if (in_ready) done = 1;
            align();
        end
        in_valid = 1'b0;
        if (!done) check($sformatf("accept_timeout[%0d]", id), 0, 1);
    endtask

    task automatic drain();
        bit done = 0;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clk);
            if (q_exp.size() == 0 && !out_valid) done = 1;
        end
        check("drain_complete", {31'd0, done}, 1);
        align();
    endtask

    // Scoreboard and signature model, sampled on the falling edge.
    initial begin : monitor
        logic          prev_stall;
        logic [OW-1:0] prev_data;
        logic [OW-1:0] e;
        int            id;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                q_exp.delete();
                q_id.delete();
                msig       = '0;
                mcnt       = '0;
                prev_stall = 1'b0;
            end else begin
                check("sig", sig, msig);
                check("res_cnt", res_cnt, mcnt);
                if (prev_stall) begin
                    check("hold_valid", out_valid, 1);
                    check("hold_data", out_data, prev_data);
                end
                if (out_valid && out_ready) begin
                    if (q_exp.size() == 0) begin
                        check("unexpected_output", out_data, 32'hFFFF_FFFF);
                        e = out_data;
                    end else begin
                        e  = q_exp.pop_front();
                        id = q_id.pop_front();
                        check($sformatf("out_data[%0d]", id), out_data, e);
                    end
                    if (sig_clr) begin
                        msig = e;
                        mcnt = 1;
                    end else begin
                        msig = {msig[OW-2:0], msig[OW-1]} ^ e;
                        mcnt = mcnt + 1'b1;
                    end
                end else if (sig_clr) begin
                    msig = '0;
                    mcnt = '0;
                end
                if (in_valid && in_ready) begin
                    q_exp.push_back(cur_exp);
                    q_id.push_back(cur_id);
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int   k;
        vec_t v01;
        vec_t v03;
        vec_t vr;

        vecs[0]  = '{OP_ADD,     4'hF, 4'h1, 1'b1, 1'b1, 6'h00};
        vecs[1]  = '{OP_ADD,     4'hF, 4'h1, 1'b1, 1'b0, 6'h10};
        vecs[2]  = '{OP_ASHR,    4'h8, 4'h1, 1'b1, 1'b1, 6'h3C};
        vecs[3]  = '{OP_ASHR,    4'h8, 4'h7, 1'b1, 1'b1, 6'h3F};
        vecs[4]  = '{OP_ASHR,    4'h8, 4'h1, 1'b0, 1'b0, 6'h04};
        vecs[5]  = '{OP_LT,      4'h8, 4'h1, 1'b1, 1'b1, 6'h01};
        vecs[6]  = '{OP_LT,      4'h8, 4'h1, 1'b0, 1'b1, 6'h00};
        vecs[7]  = '{OP_RED_XOR, 4'h7, 4'h0, 1'b0, 1'b0, 6'h01};
        vecs[8]  = '{OP_SUB,     4'h3, 4'h5, 1'b0, 1'b0, 6'h3E};
        vecs[9]  = '{OP_AND,     4'hC, 4'hA, 1'b1, 1'b1, 6'h38};
        vecs[10] = '{OP_OR,      4'h5, 4'hA, 1'b0, 1'b0, 6'h0F};
        vecs[11] = '{OP_XOR,     4'h8, 4'h1, 1'b1, 1'b1, 6'h39};
        vecs[12] = '{OP_XNOR,    4'h6, 4'h3, 1'b0, 1'b0, 6'h3A};
        vecs[13] = '{OP_SHL,     4'h3, 4'h4, 1'b0, 1'b0, 6'h30};
        vecs[14] = '{OP_SHL,     4'hF, 4'h2, 1'b1, 1'b1, 6'h3C};
        vecs[15] = '{OP_SHL,     4'hF, 4'h6, 1'b0, 1'b0, 6'h00};
        vecs[16] = '{OP_SHR,     4'h8, 4'h1, 1'b1, 1'b1, 6'h1C};
        vecs[17] = '{OP_SHR,     4'hF, 4'hF, 1'b1, 1'b1, 6'h00};
        vecs[18] = '{OP_LE,      4'hF, 4'hF, 1'b1, 1'b1, 6'h01};
        vecs[19] = '{OP_LE,      4'h2, 4'h1, 1'b0, 1'b0, 6'h00};
        vecs[20] = '{OP_EQ,      4'h8, 4'h8, 1'b1, 1'b1, 6'h01};
        vecs[21] = '{OP_EQ,      4'h8, 4'h7, 1'b1, 1'b0, 6'h00};
        vecs[22] = '{OP_RED_AND, 4'hF, 4'h0, 1'b0, 1'b0, 6'h01};
        vecs[23] = '{OP_RED_AND, 4'h7, 4'h0, 1'b0, 1'b0, 6'h00};
        vecs[24] = '{OP_RED_OR,  4'h0, 4'h0, 1'b0, 1'b0, 6'h00};
        vecs[25] = '{OP_RED_OR,  4'h4, 4'h0, 1'b0, 1'b0, 6'h01};
        vecs[26] = '{OP_MUX,     4'h0, 4'h5, 1'b0, 1'b0, 6'h3A};
        vecs[27] = '{OP_MUX,     4'h1, 4'h5, 1'b1, 1'b1, 6'h05};
        vecs[28] = '{OP_MUX,     4'h2, 4'h9, 1'b1, 1'b1, 6'h39};
        vecs[29] = '{OP_MUX,     4'h0, 4'h9, 1'b1, 1'b1, 6'h06};
        vecs[30] = '{OP_ASHR,    4'h8, 4'h2, 1'b1, 1'b1, 6'h3E};
        vecs[31] = '{OP_ASHR,    4'hF, 4'h7, 1'b1, 1'b0, 6'h00};
        vecs[32] = '{OP_ADD,     4'h7, 4'h7, 1'b1, 1'b1, 6'h0E};
        vecs[33] = '{OP_ADD,     4'h8, 4'h8, 1'b1, 1'b1, 6'h30};
        vecs[34] = '{OP_LT,      4'h1, 4'h8, 1'b1, 1'b1, 6'h00};
        vecs[35] = '{OP_LT,      4'h1, 4'h8, 1'b0, 1'b0, 6'h01};
        vecs[36] = '{OP_SHL,     4'h1, 4'h5, 1'b1, 1'b1, 6'h20};
        vecs[37] = '{OP_SHR,     4'hC, 4'h0, 1'b1, 1'b1, 6'h3C};

        bp[0] = '{OP_ADD, 4'h1, 4'h1, 1'b0, 1'b0, 6'h02};
        bp[1] = '{OP_ADD, 4'h2, 4'h2, 1'b0, 1'b0, 6'h04};
        bp[2] = '{OP_ADD, 4'h3, 4'h3, 1'b0, 1'b0, 6'h06};
        bp[3] = '{OP_ADD, 4'h4, 4'h4, 1'b0, 1'b0, 6'h08};

        v01 = '{OP_ADD, 4'h1, 4'h0, 1'b0, 1'b0, 6'h01};
        v03 = '{OP_ADD, 4'h1, 4'h2, 1'b0, 1'b0, 6'h03};
        vr  = '{OP_XOR, 4'h5, 4'hA, 1'b0, 1'b0, 6'h0F};

        reset     = 1'b1;
        in_valid  = 1'b0;
        opcode    = '0;
        a         = '0;
        b         = '0;
        a_signed  = 1'b0;
        b_signed  = 1'b0;
        out_ready = 1'b0;
        sig_clr   = 1'b0;
        cur_exp   = '0;
        cur_id    = 0;
        repeat (3) align();
        reset = 1'b0;

        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_sig", sig, 0);
        check("rst_res_cnt", res_cnt, 0);
        check("rst_in_ready", in_ready, 1);
        align();

        // Full-rate table run.
        out_ready = 1'b1;
        for (int i = 0; i < NVEC; i++) send(vecs[i], i);
        drain();
        check("table_res_cnt", res_cnt, NVEC);

        // Clear with no handshake, then two results.
        out_ready = 1'b0;
        send(v01, 100);
        send(v03, 101);
        repeat (2) align();
        sig_clr = 1'b1;
        align();
        sig_clr   = 1'b0;
        out_ready = 1'b1;
        repeat (2) align();
        out_ready = 1'b0;
        @(negedge clk);
        check("clr_sig", sig, 6'h01);
        check("clr_res_cnt", res_cnt, 2);
        align();

        // Clear on the second handshake.
        send(v01, 102);
        send(v03, 103);
        repeat (2) align();
        out_ready = 1'b1;
        align();
        sig_clr = 1'b1;
        align();
        sig_clr   = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        check("clr_hs_sig", sig, 6'h03);
        check("clr_hs_res_cnt", res_cnt, 1);
        align();

        // Back-pressure: only two requests fit while the output is stalled.
        k = 0;
        in_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            set_vec(bp[k], 200 + k);
            @(negedge clk);
            if (in_ready) k++;
            align();
        end
        check("bp_accepted", k, 2);
        @(negedge clk);
        check("bp_in_ready", in_ready, 0);
        align();
        out_ready = 1'b1;
        for (int t = 0; t < 50 && k < 4; t++) begin
            set_vec(bp[k], 200 + k);
            @(negedge clk);
            if (in_ready) k++;
            align();
        end
        in_valid = 1'b0;
        check("bp_all_accepted", k, 4);
        drain();

        // Reset with two results in flight.
        out_ready = 1'b0;
        send(vr, 300);
        send(v03, 301);
        repeat (2) align();
        reset = 1'b1;
        align();
        reset = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_sig", sig, 0);
        check("midrst_res_cnt", res_cnt, 0);
        check("midrst_in_ready", in_ready, 1);
        align();
        out_ready = 1'b1;
        repeat (6) align();
        send(vr, 302);
        drain();
        check("post_rst_res_cnt", res_cnt, 1);
        check("post_rst_sig", sig, 6'h0F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
